systolic_array_feeder: RTL
==========================

# systolic_array_feeder

Operand feeder that sits in front of the covariance-unit systolic array and drives its `A_in`/`B_in` lanes and `start` strobe. Over a valid/ready handshake it accepts one N×N tile of A (row-packed) and one N×N tile of B (column-packed), holds both, then streams them to the array in diagonal (skewed) order with zero padding. It then waits for the array's `done` before accepting the next tile pair.

## Interface
- `DATA_WIDTH`, 8, element width in bits
- `N`, 2, array dimension (lanes per operand bus)
- `FEED_CYCLES`, 4, number of feed cycles per tile; must be ≥ 2N−1 (4 matches the array's MAX_CLK)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  upstream word valid
- `in_ready`  out  1  feeder can accept a word
- `in_data`  in  N*DATA_WIDTH  packed row of A or column of B; lane k at bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]
- `a_feed`  out  N*DATA_WIDTH  to array `A_in`; lane i drives array row i
- `b_feed`  out  N*DATA_WIDTH  to array `B_in`; lane j drives array column j
- `start`  out  1  one-cycle pulse to the array control unit
- `done_in`  in  1  array `done`
- `busy`  out  1  high in FEED and WAIT_DONE

## Operation
- States: LOAD → FEED → WAIT_DONE → LOAD.
- LOAD:
  - `in_ready`=1.
  - Each `in_valid && in_ready` cycle stores `in_data` into word slot `load_cnt` and increments `load_cnt`.
  - Slots 0..N−1 hold A rows 0..N−1 (lane k = A[r][k]).
  - Slots N..2N−1 hold B columns 0..N−1 (lane k = B[k][c]).
  - The transfer with `load_cnt`=2N−1 moves the state to FEED and clears `feed_cnt`.
- FEED, at feed cycle t (0..FEED_CYCLES−1):
  - a_feed lane i = A[i][t−i] if 0 ≤ t−i < N, else 0.
  - b_feed lane j = B[t−j][j] if 0 ≤ t−j < N, else 0.
  - `start`=1 only at t=0.
  - After t=FEED_CYCLES−1, go to WAIT_DONE.
- WAIT_DONE: feeds are 0. When `done_in` is seen (or the sticky done flag is set), go to LOAD, clear `load_cnt` and the flag.
- `done_in` arriving during FEED sets the sticky done flag so the event is not lost. `done_in` during LOAD is ignored.
- `in_ready`=0 in FEED and WAIT_DONE; `in_data` is not sampled there.
- No arithmetic. Values pass through unchanged. Counters are $clog2-sized: `load_cnt` covers 0..2N−1, `feed_cnt` covers 0..FEED_CYCLES−1.

## Timing
- Reset values: state LOAD, `in_ready`=1 (after reset release), `a_feed`=0, `b_feed`=0, `start`=0, `busy`=0, counters 0, done flag 0, tile registers 0.
- All outputs are registered, except `in_ready` and `busy`, which decode directly from state.
- Latency: the first FEED cycle (`start`=1, t=0 data) is the cycle immediately after the clock edge that accepts the 2N-th word.
- `start` is asserted in the same cycle as the t=0 feed data.
- Back-to-back tiles: the earliest next `in_ready`=1 is the cycle after `done_in` is sampled in WAIT_DONE. If the done flag was set during FEED, this is the cycle after FEED ends.
- `in_valid` with `in_ready`=0 means no transfer; upstream holds its data.
- `rst` mid-FEED or mid-WAIT_DONE: all outputs drop to reset values immediately (asynchronous), and the partial tile is discarded.

## Structure
- Shared package/header `pca_pkg`: DATA_WIDTH default, N default, state encodings (LOAD, FEED, WAIT_DONE), and a lane-slice macro/function.
- Sub-module `systolic_tile_buffer`: 2N word registers with a write port and a combinational diagonal-select read port indexed by t.
- Top module: FSM, counters, done flag, and output registers.

## Test plan
1. Reset release → `in_ready`=1; `a_feed`, `b_feed`, `start`, `busy` all 0.
2. A=[[1,2],[3,4]], B=[[5,6],[7,8]], words 16'h0201, 16'h0403, 16'h0705, 16'h0806 → `a_feed` = 0001, 0302, 0400, 0000 and `b_feed` = 0005, 0607, 0800, 0000 over t=0..3; `start`=1 only at t=0.
3. `in_valid` toggled with gaps during LOAD → same feed sequence as scenario 2; no word lost or duplicated; `in_ready`=0 throughout FEED and WAIT_DONE.
4. `done_in` pulsed at t=2 of FEED → `in_ready`=1 in the cycle right after t=3; second tile loads and feeds correctly.
5. `rst` asserted at t=1 → outputs 0 the same cycle, state LOAD; a fresh full tile load then gives the scenario 2 sequence.
6. All elements 8'hFF → lanes carry FF unmodified at their diagonal slots; zero padding elsewhere.

Source files
------------

// File: rtl/pca_pkg.sv
// Shared definitions for the covariance-unit operand path: default sizes,
// feeder state encoding and a lane-slice helper.
package pca_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_N          = 2;

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        FEED      = 2'd1,
        WAIT_DONE = 2'd2
    } feeder_state_t;

    // Lane k of a packed bus occupies bits [(k+1)*width-1 : k*width].
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/systolic_tile_buffer.sv
// Holds one A tile (rows, slots 0..N-1) and one B tile (columns, slots N..2N-1)
// and presents the skewed diagonal of both for feed index rd_t.
module systolic_tile_buffer
    import pca_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int N          = DEFAULT_N,
    parameter int AW         = $clog2(2 * N),
    parameter int TW         = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [N*DATA_WIDTH-1:0] wr_data,
    input  logic [TW-1:0]           rd_t,
    output logic [N*DATA_WIDTH-1:0] a_diag,
    output logic [N*DATA_WIDTH-1:0] b_diag
);

    localparam int WW    = N * DATA_WIDTH;
    localparam int SLOTS = 2 * N;

    logic [WW-1:0] words [SLOTS];
    logic [WW-1:0] view  [SLOTS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SLOTS; s++) begin
                words[s] <= '0;
            end
        end else if (wr_en) begin
            words[wr_addr] <= wr_data;
        end
    end

    // Bypass the word being written so the t=0 diagonal can be registered on
    // the same edge that accepts the final word of the tile.
    always_comb begin
        for (int s = 0; s < SLOTS; s++) begin
            view[s] = (wr_en && (wr_addr == AW'(s))) ? wr_data : words[s];
        end
    end

    always_comb begin
        a_diag = '0;
        b_diag = '0;
        for (int lane = 0; lane < N; lane++) begin
            if ((int'(rd_t) >= lane) && (int'(rd_t) - lane < N)) begin
                a_diag[lane_lsb(lane, DATA_WIDTH) +: DATA_WIDTH] =
                    view[AW'(lane)][lane_lsb(int'(rd_t) - lane, DATA_WIDTH) +: DATA_WIDTH];
                b_diag[lane_lsb(lane, DATA_WIDTH) +: DATA_WIDTH] =
                    view[AW'(N + lane)][lane_lsb(int'(rd_t) - lane, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/systolic_array_feeder.sv
// Loads an A/B tile pair over valid/ready, streams it to the systolic array in
// skewed order with a start pulse, then waits for the array's done.
module systolic_array_feeder
    import pca_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int N           = DEFAULT_N,
    parameter int FEED_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] in_data,
    output logic [N*DATA_WIDTH-1:0] a_feed,
    output logic [N*DATA_WIDTH-1:0] b_feed,
    output logic                    start,
    input  logic                    done_in,
    output logic                    busy
);

    localparam int WW  = N * DATA_WIDTH;
    localparam int LCW = $clog2(2 * N);
    localparam int FCW = (FEED_CYCLES > 1) ? $clog2(FEED_CYCLES) : 1;
    localparam logic [LCW-1:0] LAST_WORD = LCW'(2 * N - 1);
    localparam logic [FCW-1:0] LAST_FEED = FCW'(FEED_CYCLES - 1);

    feeder_state_t  state, state_next;
    logic [LCW-1:0] load_cnt, load_cnt_next;
    logic [FCW-1:0] feed_cnt, feed_cnt_next;
    logic           done_flag, done_flag_next;
    logic [WW-1:0]  a_next, b_next;
    logic           start_next;
    logic           wr_en;
    logic [FCW-1:0] rd_t;
    logic [WW-1:0]  a_diag, b_diag;

    systolic_tile_buffer #(
        .DATA_WIDTH(DATA_WIDTH),
        .N         (N),
        .AW        (LCW),
        .TW        (FCW)
    ) u_tile_buffer (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_addr(load_cnt),
        .wr_data(in_data),
        .rd_t   (rd_t),
        .a_diag (a_diag),
        .b_diag (b_diag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            load_cnt  <= '0;
            feed_cnt  <= '0;
            done_flag <= 1'b0;
            a_feed    <= '0;
            b_feed    <= '0;
            start     <= 1'b0;
        end else begin
            state     <= state_next;
            load_cnt  <= load_cnt_next;
            feed_cnt  <= feed_cnt_next;
            done_flag <= done_flag_next;
            a_feed    <= a_next;
            b_feed    <= b_next;
            start     <= start_next;
        end
    end

    // The feed registers are loaded one cycle ahead, so the diagonal read
    // always targets the index that will be on the outputs next cycle.
    always_comb begin
        state_next     = state;
        load_cnt_next  = load_cnt;
        feed_cnt_next  = feed_cnt;
        done_flag_next = done_flag;
        a_next         = '0;
        b_next         = '0;
        start_next     = 1'b0;
        wr_en          = 1'b0;
        rd_t           = '0;
        case (state)
            LOAD: begin
                if (in_valid) begin
                    wr_en         = 1'b1;
                    load_cnt_next = load_cnt + LCW'(1);
                    if (load_cnt == LAST_WORD) begin
                        state_next    = FEED;
                        feed_cnt_next = '0;
                        a_next        = a_diag;
                        b_next        = b_diag;
                        start_next    = 1'b1;
                    end
                end
            end
            FEED: begin
                rd_t = feed_cnt + FCW'(1);
                if (done_in) begin
                    done_flag_next = 1'b1;
                end
                if (feed_cnt == LAST_FEED) begin
                    if (done_in || done_flag) begin
                        state_next     = LOAD;
                        load_cnt_next  = '0;
                        done_flag_next = 1'b0;
                    end else begin
                        state_next = WAIT_DONE;
                    end
                end else begin
                    feed_cnt_next = feed_cnt + FCW'(1);
                    a_next        = a_diag;
                    b_next        = b_diag;
                end
            end
            WAIT_DONE: begin
                if (done_in || done_flag) begin
                    state_next     = LOAD;
                    load_cnt_next  = '0;
                    done_flag_next = 1'b0;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    assign in_ready = (state == LOAD);
    assign busy     = (state != LOAD);

endmodule
